// File: rtl/branch_resolve_unit_pkg.sv
// ----------------------------------------------------------------------------
// branch_resolve_unit_pkg
// Shared definitions for the decode-stage branch resolver: datapath width,
// MIPS opcode / funct / REGIMM-rt field values for control transfers, and
// the delay-slot tracking state encoding.
// No ports (package).
// ----------------------------------------------------------------------------
package branch_resolve_unit_pkg;

    localparam int XLEN = 32;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;

    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;

    localparam logic [4:0] RT_BLTZ    = 5'b00000;
    localparam logic [4:0] RT_BGEZ    = 5'b00001;

    // IDLE: free to issue; HOLD: request issued, transfer still stalled in D;
    // SLOT: waiting for the delay-slot instruction to leave D.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HOLD = 2'b01,
        SLOT = 2'b10
    } state_e;

endpackage

// File: rtl/branch_resolve_unit_target_calc.sv
// ----------------------------------------------------------------------------
// br_target_calc
// Purely combinational decode of a control transfer: recognises the
// instruction class, evaluates its condition on the forwarded operands and
// selects the redirect target.
// Ports:
//   instr    in  32  instruction in D
//   pc_plus4 in  32  PC of that instruction + 4
//   rd1      in  32  forwarded rs value
//   rd2      in  32  forwarded rt value
//   is_xfer  out 1   a control transfer is decoded
//   is_taken out 1   the decoded transfer is taken
//   is_link  out 1   JAL or JALR
//   target   out 32  target address of the decoded transfer
// ----------------------------------------------------------------------------
module br_target_calc
    import branch_resolve_unit_pkg::*;
#(
    parameter int unsigned EN_REGIMM = 1
) (
    input  logic [XLEN-1:0] instr,
    input  logic [XLEN-1:0] pc_plus4,
    input  logic [XLEN-1:0] rd1,
    input  logic [XLEN-1:0] rd2,
    output logic            is_xfer,
    output logic            is_taken,
    output logic            is_link,
    output logic [XLEN-1:0] target
);

    logic [5:0]      opcode;
    logic [5:0]      funct;
    logic [4:0]      rt_field;
    logic [XLEN-1:0] br_tgt;
    logic [XLEN-1:0] jmp_tgt;
    logic            rs_neg;
    logic            rs_zero;

    assign opcode   = instr[31:26];
    assign funct    = instr[5:0];
    assign rt_field = instr[20:16];
    assign br_tgt   = pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00};
    assign jmp_tgt  = {pc_plus4[31:28], instr[25:0], 2'b00};
    assign rs_neg   = rd1[XLEN-1];
    assign rs_zero  = (rd1 == '0);

    // Class decode and condition evaluation. Signed tests reduce to the
    // sign bit plus a zero check. REGIMM encodings other than BLTZ/BGEZ
    // (e.g. the linking variants) are treated as ordinary instructions.
    always_comb begin
        is_xfer  = 1'b0;
        is_taken = 1'b0;
        is_link  = 1'b0;
        target   = br_tgt;
        case (opcode)
            OP_BEQ: begin
                is_xfer  = 1'b1;
                is_taken = (rd1 == rd2);
            end
            OP_BNE: begin
                is_xfer  = 1'b1;
                is_taken = (rd1 != rd2);
            end
            OP_BLEZ: begin
                is_xfer  = 1'b1;
                is_taken = rs_neg | rs_zero;
            end
            OP_BGTZ: begin
                is_xfer  = 1'b1;
                is_taken = ~rs_neg & ~rs_zero;
            end
            OP_REGIMM: begin
                if (EN_REGIMM != 0) begin
                    if (rt_field == RT_BLTZ) begin
                        is_xfer  = 1'b1;
                        is_taken = rs_neg;
                    end else if (rt_field == RT_BGEZ) begin
                        is_xfer  = 1'b1;
                        is_taken = ~rs_neg;
                    end
                end
            end
            OP_J, OP_JAL: begin
                is_xfer  = 1'b1;
                is_taken = 1'b1;
                is_link  = (opcode == OP_JAL);
                target   = jmp_tgt;
            end
            OP_SPECIAL: begin
                if (funct == FN_JR || funct == FN_JALR) begin
                    is_xfer  = 1'b1;
                    is_taken = 1'b1;
                    is_link  = (funct == FN_JALR);
                    target   = rd1;
                end
            end
            default: begin
                is_xfer = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// ----------------------------------------------------------------------------
// branch_resolve_unit
// Decode-stage control-transfer resolver feeding the PC stage redirect
// interface. Issues one IsJBrD pulse per taken transfer even across decode
// stalls, tracks the architectural delay slot, flags transfers found in the
// slot, and counts retired / taken transfers.
// Ports:
//   clk       in  1      clock, rising edge
//   rst       in  1      synchronous active-low reset
//   ValidD    in  1      D instruction valid
//   StallD    in  1      D holds its instruction
//   InstrD    in  32     instruction in D
//   PCPlus4D  in  32     PC + 4 of D instruction
//   RD1D      in  32     forwarded rs
//   RD2D      in  32     forwarded rt
//   IsJBrD    out 1      redirect request
//   NPCD      out 32     redirect target
//   LinkD     out 1      JAL/JALR in D
//   InSlotD   out 1      D instruction is a delay slot
//   BrErrD    out 1      transfer decoded in a delay slot
//   BrCnt     out CNT_W  transfers retired from D
//   TakenCnt  out CNT_W  taken transfers retired from D
// ----------------------------------------------------------------------------
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int          CNT_W     = 16,
    parameter int unsigned EN_REGIMM = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ValidD,
    input  logic             StallD,
    input  logic [XLEN-1:0]  InstrD,
    input  logic [XLEN-1:0]  PCPlus4D,
    input  logic [XLEN-1:0]  RD1D,
    input  logic [XLEN-1:0]  RD2D,
    output logic             IsJBrD,
    output logic [XLEN-1:0]  NPCD,
    output logic             LinkD,
    output logic             InSlotD,
    output logic             BrErrD,
    output logic [CNT_W-1:0] BrCnt,
    output logic [CNT_W-1:0] TakenCnt
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

    logic            is_xfer;
    logic            is_taken;
    logic            is_link;
    logic [XLEN-1:0] target;
    logic            take;
    logic            retire;
    logic            active;

    br_target_calc #(
        .EN_REGIMM (EN_REGIMM)
    ) u_calc (
        .instr    (InstrD),
        .pc_plus4 (PCPlus4D),
        .rd1      (RD1D),
        .rd2      (RD2D),
        .is_xfer  (is_xfer),
        .is_taken (is_taken),
        .is_link  (is_link),
        .target   (target)
    );

    // The request may only fire from IDLE, so a stalled transfer cannot
    // re-issue while it sits in HOLD and a transfer in the slot is suppressed.
    // Every output is held inactive while reset is asserted.
    assign take    = rst & ValidD & is_taken & (state_q == IDLE);
    assign active  = rst & ValidD & ~StallD;
    assign retire  = active & is_xfer & (state_q != SLOT);

    assign IsJBrD  = take;
    assign NPCD    = (rst && is_taken) ? target : PCPlus4D;
    // Only the redirect request may be high during a stall.
    assign LinkD   = active & is_link;
    assign InSlotD = active & (state_q == SLOT);
    assign BrErrD  = InSlotD & is_xfer;

    assign BrCnt    = br_cnt_q;
    assign TakenCnt = taken_cnt_q;

    // Delay-slot tracking. Only taken transfers enter the slot; bubbles
    // and stalled cycles leave SLOT pending until a real instruction retires.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (take) begin
                    state_d = StallD ? HOLD : SLOT;
                end
            end
            HOLD: begin
                if (!StallD) begin
                    state_d = SLOT;
                end
            end
            SLOT: begin
                if (ValidD && !StallD) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Statistics counters advance when a transfer leaves D, wrapping freely.
    always_comb begin
        br_cnt_d    = br_cnt_q;
        taken_cnt_d = taken_cnt_q;
        if (retire) begin
            br_cnt_d = br_cnt_q + CNT_W'(1);
            if (is_taken) begin
                taken_cnt_d = taken_cnt_q + CNT_W'(1);
            end
        end
    end

    // State and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            br_cnt_q    <= '0;
            taken_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            br_cnt_q    <= br_cnt_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// ----------------------------------------------------------------------------
// tb_branch_resolve_unit
// Directed bench for branch_resolve_unit: a linear sequence of cycles, each
// driving D-stage inputs and comparing outputs to hand-computed constants.
// ----------------------------------------------------------------------------
module tb_branch_resolve_unit;

    logic        clk;
    logic        rst;
    logic        ValidD;
    logic        StallD;
    logic [31:0] InstrD;
    logic [31:0] PCPlus4D;
    logic [31:0] RD1D;
    logic [31:0] RD2D;
    logic        IsJBrD;
    logic [31:0] NPCD;
    logic        LinkD;
    logic        InSlotD;
    logic        BrErrD;
    logic [15:0] BrCnt;
    logic [15:0] TakenCnt;

    int vectors;
    int miscompares;

    branch_resolve_unit #(
        .CNT_W     (16),
        .EN_REGIMM (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ValidD   (ValidD),
        .StallD   (StallD),
        .InstrD   (InstrD),
        .PCPlus4D (PCPlus4D),
        .RD1D     (RD1D),
        .RD2D     (RD2D),
        .IsJBrD   (IsJBrD),
        .NPCD     (NPCD),
        .LinkD    (LinkD),
        .InSlotD  (InSlotD),
        .BrErrD   (BrErrD),
        .BrCnt    (BrCnt),
        .TakenCnt (TakenCnt)
    );

    // 10-unit free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] NOP = 32'h0000_0000;

    function automatic logic [31:0] encI(input logic [5:0] op, input logic [4:0] rt,
                                          input logic [15:0] imm);
        return {op, 5'd1, rt, imm};
    endfunction

    function automatic logic [31:0] encJ(input logic [5:0] op, input logic [25:0] idx);
        return {op, idx};
    endfunction

    // Drive one cycle's worth of D-stage inputs, then let them settle.
    task automatic applyStimulus(input logic v, input logic s, input logic [31:0] instr,
                                 input logic [31:0] pc4, input logic [31:0] rd1,
                                 input logic [31:0] rd2);
        ValidD   = v;
        StallD   = s;
        InstrD   = instr;
        PCPlus4D = pc4;
        RD1D     = rd1;
        RD2D     = rd2;
        #1;
    endtask

    // One comparison of an observed value against its expected constant.
    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are then sampled mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        applyStimulus(1'b0, 1'b0, NOP, 32'h0, 32'h0, 32'h0);
        tick();
        tick();

        $display("[TB] reset behaviour");
        applyStimulus(1'b1, 1'b0, encJ(6'b000011, 26'h10), 32'h1004, 32'h0, 32'h0);
        checkOutput("rst_isjbr", {31'b0, IsJBrD}, 32'h0);
        checkOutput("rst_link", {31'b0, LinkD}, 32'h0);
        checkOutput("rst_npc", NPCD, 32'h1004);
        checkOutput("rst_brcnt", {16'b0, BrCnt}, 32'h0);
        checkOutput("rst_tkcnt", {16'b0, TakenCnt}, 32'h0);
        tick();
        checkOutput("rst_brcnt_hold", {16'b0, BrCnt}, 32'h0);
        rst = 1'b1;

        $display("[TB] taken BEQ");
        applyStimulus(1'b1, 1'b0, encI(6'b000100, 5'd2, 16'h0003), 32'h3004, 32'd5, 32'd5);
        checkOutput("beq_isjbr", {31'b0, IsJBrD}, 32'h1);
        checkOutput("beq_npc", NPCD, 32'h3010);
        checkOutput("beq_inslot", {31'b0, InSlotD}, 32'h0);
        tick();
        applyStimulus(1'b1, 1'b0, NOP, 32'h3008, 32'd0, 32'd0);
        checkOutput("beq_slot_isjbr", {31'b0, IsJBrD}, 32'h0);
        checkOutput("beq_slot_inslot", {31'b0, InSlotD}, 32'h1);
        checkOutput("beq_brcnt", {16'b0, BrCnt}, 32'h1);
        checkOutput("beq_tkcnt", {16'b0, TakenCnt}, 32'h1);
        tick();

        $display("[TB] stalled BNE");
        applyStimulus(1'b1, 1'b1, encI(6'b000101, 5'd2, 16'h0010), 32'h4004, 32'd1, 32'd2);
        checkOutput("bne_st1_isjbr", {31'b0, IsJBrD}, 32'h1);
        checkOutput("bne_st1_npc", NPCD, 32'h4044);
        tick();
        checkOutput("bne_st2_isjbr", {31'b0, IsJBrD}, 32'h0);
        checkOutput("bne_st2_brcnt", {16'b0, BrCnt}, 32'h1);
        tick();
        checkOutput("bne_st3_isjbr", {31'b0, IsJBrD}, 32'h0);
        tick();
        applyStimulus(1'b1, 1'b0, encI(6'b000101, 5'd2, 16'h0010), 32'h4004, 32'd1, 32'd2);
        checkOutput("bne_rel_isjbr", {31'b0, IsJBrD}, 32'h0);
        checkOutput("bne_rel_tkcnt", {16'b0, TakenCnt}, 32'h1);
        tick();
        applyStimulus(1'b1, 1'b0, NOP, 32'h4008, 32'd0, 32'd0);
        checkOutput("bne_slot_inslot", {31'b0, InSlotD}, 32'h1);
        checkOutput("bne_brcnt", {16'b0, BrCnt}, 32'h2);
        checkOutput("bne_tkcnt", {16'b0, TakenCnt}, 32'h2);
        tick();

        $display("[TB] J and JALR");
        applyStimulus(1'b1, 1'b0, encJ(6'b000010, 26'h0000C10), 32'h3008, 32'd0, 32'd0);
        checkOutput("j_isjbr", {31'b0, IsJBrD}, 32'h1);
        checkOutput("j_npc", NPCD, 32'h0000_3040);
        checkOutput("j_link", {31'b0, LinkD}, 32'h0);
        tick();
        applyStimulus(1'b1, 1'b0, NOP, 32'h300C, 32'd0, 32'd0);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h0020_F809, 32'h5004, 32'h3100, 32'd0);
        checkOutput("jalr_isjbr", {31'b0, IsJBrD}, 32'h1);
        checkOutput("jalr_npc", NPCD, 32'h3100);
        checkOutput("jalr_link", {31'b0, LinkD}, 32'h1);
        checkOutput("jalr_brcnt", {16'b0, BrCnt}, 32'h3);
        tick();
        applyStimulus(1'b1, 1'b0, NOP, 32'h5008, 32'd0, 32'd0);
        checkOutput("jalr_tkcnt", {16'b0, TakenCnt}, 32'h4);
        tick();

        $display("[TB] branch in delay slot");
        applyStimulus(1'b1, 1'b0, encI(6'b000100, 5'd2, 16'h0001), 32'h6004, 32'd7, 32'd7);
        checkOutput("ds_first_isjbr", {31'b0, IsJBrD}, 32'h1);
        tick();
        applyStimulus(1'b1, 1'b0, encI(6'b000101, 5'd2, 16'h0004), 32'h6008, 32'd1, 32'd2);
        checkOutput("ds_err", {31'b0, BrErrD}, 32'h1);
        checkOutput("ds_isjbr", {31'b0, IsJBrD}, 32'h0);
        checkOutput("ds_inslot", {31'b0, InSlotD}, 32'h1);
        tick();
        applyStimulus(1'b1, 1'b0, NOP, 32'h600C, 32'd0, 32'd0);
        checkOutput("ds_after_inslot", {31'b0, InSlotD}, 32'h0);
        checkOutput("ds_after_err", {31'b0, BrErrD}, 32'h0);
        checkOutput("ds_brcnt", {16'b0, BrCnt}, 32'h5);
        checkOutput("ds_tkcnt", {16'b0, TakenCnt}, 32'h5);
        tick();

        $display("[TB] not-taken and REGIMM");
        applyStimulus(1'b1, 1'b0, encI(6'b000111, 5'd0, 16'h0004), 32'h7004, 32'hFFFF_FFFF, 32'd0);
        checkOutput("bgtz_isjbr", {31'b0, IsJBrD}, 32'h0);
        checkOutput("bgtz_npc", NPCD, 32'h7004);
        tick();
        applyStimulus(1'b1, 1'b0, NOP, 32'h7008, 32'd0, 32'd0);
        checkOutput("bgtz_noslot", {31'b0, InSlotD}, 32'h0);
        checkOutput("bgtz_brcnt", {16'b0, BrCnt}, 32'h6);
        checkOutput("bgtz_tkcnt", {16'b0, TakenCnt}, 32'h5);
        tick();
        applyStimulus(1'b1, 1'b0, encI(6'b000001, 5'b10000, 16'h0004), 32'h7804, 32'hFFFF_FFFF, 32'd0);
        checkOutput("bltzal_isjbr", {31'b0, IsJBrD}, 32'h0);
        tick();
        applyStimulus(1'b1, 1'b0, encI(6'b000001, 5'b00000, 16'hFFFF), 32'h7104, 32'hFFFF_FFFF, 32'd0);
        checkOutput("bltz_isjbr", {31'b0, IsJBrD}, 32'h1);
        checkOutput("bltz_npc", NPCD, 32'h7100);
        checkOutput("bltzal_brcnt", {16'b0, BrCnt}, 32'h6);
        tick();
        applyStimulus(1'b1, 1'b0, NOP, 32'h7108, 32'd0, 32'd0);
        tick();
        applyStimulus(1'b1, 1'b0, encI(6'b000001, 5'b00001, 16'h0002), 32'h7204, 32'h0000_0000, 32'd0);
        checkOutput("bgez_npc", NPCD, 32'h720C);
        tick();
        applyStimulus(1'b1, 1'b0, NOP, 32'h7208, 32'd0, 32'd0);
        checkOutput("bgez_brcnt", {16'b0, BrCnt}, 32'h8);
        checkOutput("bgez_tkcnt", {16'b0, TakenCnt}, 32'h7);
        tick();

        $display("[TB] bubbles in delay slot");
        applyStimulus(1'b1, 1'b0, encJ(6'b000010, 26'h0000100), 32'h8004, 32'd0, 32'd0);
        checkOutput("jb_npc", NPCD, 32'h0000_0400);
        tick();
        applyStimulus(1'b0, 1'b0, NOP, 32'h8008, 32'd0, 32'd0);
        checkOutput("jb_bub1_inslot", {31'b0, InSlotD}, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, encJ(6'b000010, 26'h0000200), 32'h8008, 32'd0, 32'd0);
        checkOutput("jb_bub2_inslot", {31'b0, InSlotD}, 32'h0);
        checkOutput("jb_bub2_isjbr", {31'b0, IsJBrD}, 32'h0);
        tick();
        applyStimulus(1'b1, 1'b0, NOP, 32'h8008, 32'd0, 32'd0);
        checkOutput("jb_valid_inslot", {31'b0, InSlotD}, 32'h1);
        tick();
        applyStimulus(1'b1, 1'b0, NOP, 32'h800C, 32'd0, 32'd0);
        checkOutput("jb_after_inslot", {31'b0, InSlotD}, 32'h0);
        checkOutput("jb_brcnt", {16'b0, BrCnt}, 32'h9);
        tick();

        $display("[TB] reset mid-HOLD");
        applyStimulus(1'b1, 1'b1, encI(6'b000100, 5'd2, 16'h0002), 32'h9004, 32'd3, 32'd3);
        checkOutput("rh_isjbr", {31'b0, IsJBrD}, 32'h1);
        checkOutput("rh_npc", NPCD, 32'h900C);
        tick();
        rst = 1'b0;
        #1;
        checkOutput("rh_rst_isjbr", {31'b0, IsJBrD}, 32'h0);
        checkOutput("rh_rst_npc", NPCD, 32'h9004);
        tick();
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, NOP, 32'h9004, 32'd0, 32'd0);
        checkOutput("rh_post_isjbr", {31'b0, IsJBrD}, 32'h0);
        checkOutput("rh_post_inslot", {31'b0, InSlotD}, 32'h0);
        checkOutput("rh_post_brcnt", {16'b0, BrCnt}, 32'h0);
        checkOutput("rh_post_tkcnt", {16'b0, TakenCnt}, 32'h0);
        tick();
        applyStimulus(1'b1, 1'b0, encI(6'b000100, 5'd2, 16'h0002), 32'h9004, 32'd3, 32'd3);
        checkOutput("rh_again_isjbr", {31'b0, IsJBrD}, 32'h1);
        tick();
        applyStimulus(1'b1, 1'b0, NOP, 32'h9008, 32'd0, 32'd0);
        checkOutput("rh_slot_isjbr", {31'b0, IsJBrD}, 32'h0);
        checkOutput("rh_slot_inslot", {31'b0, InSlotD}, 32'h1);
        checkOutput("rh_brcnt", {16'b0, BrCnt}, 32'h1);
        checkOutput("rh_tkcnt", {16'b0, TakenCnt}, 32'h1);
        tick();
        applyStimulus(1'b1, 1'b0, NOP, 32'h900C, 32'd0, 32'd0);
        checkOutput("rh_end_inslot", {31'b0, InSlotD}, 32'h0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Decode-stage control-transfer resolver: the producer side of the fetch-redirect interface (IsJBrD / NPCD) consumed by the PC stage.
- Decodes the instruction in D, evaluates the branch condition on forwarded operands and computes the target.
- Issues exactly one IsJBrD pulse per taken transfer, regardless of decode stalls, because the PC stage latches a request on any edge.
- Tracks the single architectural delay slot, flags illegal transfers in it, and keeps branch statistics counters.

Parameters:
- CNT_W, 16, width of the statistics counters (wrap-around).
- EN_REGIMM, 1, when 1 decode BLTZ/BGEZ (opcode 000001); when 0 treat them as non-branch.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-low reset (0 = reset, sampled on posedge clk only)
- ValidD  in  1  instruction in D is valid (not a bubble)
- StallD  in  1  D holds its instruction this cycle
- InstrD  in  32  instruction in D
- PCPlus4D  in  32  PC of D instruction + 4
- RD1D  in  32  forwarded rs value
- RD2D  in  32  forwarded rt value
- IsJBrD  out  1  one-cycle request to redirect fetch
- NPCD  out  32  redirect target, valid when IsJBrD=1
- LinkD  out  1  JAL/JALR in D, write PCPlus4D+4 to rd/$31
- InSlotD  out  1  D instruction is a delay slot
- BrErrD  out  1  control transfer decoded in a delay slot (suppressed)
- BrCnt  out  CNT_W  count of control transfers retired from D
- TakenCnt  out  CNT_W  count of taken transfers

Behaviour:
- Decoded transfers:
  - BEQ/BNE compare RD1D with RD2D.
  - BLEZ/BGTZ/BLTZ/BGEZ use a signed test of RD1D.
  - J/JAL are always taken.
  - JR/JALR (funct 001000/001001) are always taken.
- Targets:
  - Branch: PCPlus4D + (sign-extended imm16 << 2), mod 2^32.
  - J/JAL: {PCPlus4D[31:28], instr_index, 2'b00}.
  - JR/JALR: RD1D, used as-is with no alignment check.
- NPCD equals the computed target when taken, PCPlus4D otherwise. NPCD is combinational.
- "take" = ValidD & taken-transfer decoded & state==IDLE.
- IsJBrD = take. It is combinational, and it is the only output permitted to go high while StallD=1.
- FSM, state register, reset state IDLE:
  - IDLE:
    - If take and StallD, go to HOLD.
    - If take and !StallD, go to SLOT.
    - Otherwise stay.
  - HOLD: the branch is still in D and the request has already been issued.
    - IsJBrD is forced to 0.
    - If !StallD, go to SLOT.
  - SLOT: InSlotD=1 when ValidD.
    - A transfer decoded here gives BrErrD=1 and IsJBrD=0.
    - Leave to IDLE on the first cycle with ValidD & !StallD.
    - Bubbles (ValidD=0) do not consume the slot.
- LinkD: combinational decode of JAL/JALR & ValidD. It is independent of state, including in SLOT.
- Counters:
  - Increment on the cycle a transfer leaves D (ValidD & !StallD & transfer decoded & not in SLOT).
  - TakenCnt additionally requires the taken condition.
  - Conditional not-taken branches count in BrCnt only.
  - Both counters wrap at 2^CNT_W.
- Reset (rst=0 at posedge):
  - State returns to IDLE and counters clear to 0.
  - Outputs in the same cycle are forced to 0 while rst=0: IsJBrD=0, BrErrD=0, InSlotD=0, LinkD=0, NPCD=PCPlus4D.
  - Reset mid-HOLD or mid-SLOT discards the pending slot; no extra IsJBrD is issued afterwards.
- Simultaneous events: a not-taken conditional branch does not enter SLOT. The delay slot is tracked only for taken transfers, matching the PC stage, which inserts no slot tracking when not redirected.

Decomposition:
- Shared package: opcode/funct localparams (OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_REGIMM, OP_J, OP_JAL, FN_JR, FN_JALR), FSM state encoding (IDLE/HOLD/SLOT), and the 32-bit width constant.
- One sub-module, br_target_calc: combinational condition evaluation and target mux.
- FSM and counters stay in the top module.

Test Plan:
- Taken BEQ: PCPlus4D=0x3004, RD1D=RD2D=5, imm=0x0003, StallD=0 → IsJBrD=1 for 1 cycle, NPCD=0x3010. Next valid instruction has InSlotD=1. TakenCnt=1, BrCnt=1.
- Stalled branch: BNE taken with StallD=1 for 3 cycles, then 0 → IsJBrD high only in the first cycle, state HOLD→SLOT. Counters increment once, on release.
- J and JR:
  - J instr_index=0x0000C10, PCPlus4D=0x3008 → NPCD=0x00003040.
  - JALR RD1D=0x3100 → NPCD=0x3100, LinkD=1.
- Branch in delay slot: taken BEQ followed by taken BNE in the slot → second instruction gives BrErrD=1, IsJBrD=0, counters unchanged for it. State returns to IDLE afterwards.
- Not-taken / bubble: BGTZ RD1D=0xFFFFFFFF → IsJBrD=0, BrCnt+1, TakenCnt unchanged, no SLOT. A taken J followed by 2 bubbles then a valid instruction → InSlotD=1 only on that valid instruction.
- Reset mid-HOLD: rst=0 for one cycle while in HOLD → state IDLE, counters 0, no IsJBrD after release. The same taken instruction re-presented afterwards issues exactly one new pulse.
